// File: rtl/amba_cmd_master.sv
// Host-side command framer: assembles SYNC/ADDR/DATA/CHK byte frames from the
// serial receiver and issues one valid/ready register write per good frame.
module amba_cmd_master #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  ADDR_MIN    = 8'h20,
    parameter logic [7:0]  ADDR_MAX    = 8'h24,
    parameter int unsigned WR_TIMEOUT  = 255,
    parameter int unsigned GAP_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       bus_valid,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_data,
    input  logic       bus_ready,
    output logic       wr_done,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned WW = $clog2(WR_TIMEOUT + 1);
    localparam int unsigned GW = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_WRITE
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_req_t;

    state_t        state, state_n;
    logic [7:0]    addr_q, addr_n;
    logic [7:0]    data_q, data_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [WW-1:0] wr_cnt, wr_n;
    wr_req_t       req_q, req_n;
    logic          valid_n;
    logic          done_n, ferr_n, tout_n, ovr_n;

    logic          accept;
    logic          gap_hit;
    logic          wr_hit;
    logic          addr_ok;
    logic [7:0]    exp_chk;

    assign rx_ready = (state != S_WRITE);
    assign busy     = (state != S_HUNT);
    assign accept   = rx_valid && rx_ready;
    assign gap_hit  = (gap_cnt == GW'(GAP_TIMEOUT - 1));
    assign wr_hit   = (wr_cnt == WW'(WR_TIMEOUT - 1));
    assign exp_chk  = SYNC_BYTE ^ addr_q ^ data_q;
    assign addr_ok  = (addr_q >= ADDR_MIN) && (addr_q <= ADDR_MAX);

    assign bus_addr = req_q.addr;
    assign bus_data = req_q.data;

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        data_n  = data_q;
        gap_n   = gap_cnt;
        wr_n    = wr_cnt;
        req_n   = req_q;
        valid_n = bus_valid;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        tout_n  = 1'b0;
        ovr_n   = rx_valid && !rx_ready;

        case (state)
            S_HUNT: begin
                gap_n = '0;
                if (accept && rx_data == SYNC_BYTE)
                    state_n = S_ADDR;
            end

            S_ADDR, S_DATA, S_CHK: begin
                if (accept) begin
                    gap_n = '0;
                    case (state)
                        S_ADDR: begin
                            addr_n  = rx_data;
                            state_n = S_DATA;
                        end
                        S_DATA: begin
                            data_n  = rx_data;
                            state_n = S_CHK;
                        end
                        default: begin
                            if (rx_data != exp_chk || !addr_ok) begin
                                ferr_n  = 1'b1;
                                state_n = S_HUNT;
                            end else begin
                                req_n   = '{addr: addr_q, data: data_q};
                                wr_n    = '0;
                                state_n = S_WRITE;
                            end
                        end
                    endcase
                end else if (gap_hit) begin
                    // partial frame is abandoned; nothing reaches the bus
                    ferr_n  = 1'b1;
                    gap_n   = '0;
                    state_n = S_HUNT;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end

            S_WRITE: begin
                // first WRITE cycle only raises bus_valid; the timer then
                // counts bus_valid cycles so the timeout bounds the request
                if (!bus_valid) begin
                    valid_n = 1'b1;
                    wr_n    = '0;
                end else if (bus_ready) begin
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                    wr_n    = '0;
                    state_n = S_HUNT;
                end else if (wr_hit) begin
                    valid_n = 1'b0;
                    tout_n  = 1'b1;
                    wr_n    = '0;
                    state_n = S_HUNT;
                end else begin
                    wr_n = wr_cnt + WW'(1);
                end
            end

            default: begin
                state_n = S_HUNT;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_HUNT;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            data_q      <= '0;
            gap_cnt     <= '0;
            wr_cnt      <= '0;
            req_q       <= '0;
            bus_valid   <= 1'b0;
            wr_done     <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            addr_q      <= addr_n;
            data_q      <= data_n;
            gap_cnt     <= gap_n;
            wr_cnt      <= wr_n;
            req_q       <= req_n;
            bus_valid   <= valid_n;
            wr_done     <= done_n;
            frame_err   <= ferr_n;
            timeout_err <= tout_n;
            overrun     <= ovr_n;
        end
    end

endmodule
